// File: rtl/uart_sched_pkg.sv
// Shared types for the UART TX scheduler: FSM state encoding and length-width helper.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArb,
      StIssue,
      StWaitHi,
      StWaitLo
   } sched_state_e;

   // Width able to hold a byte count from 0 up to and including bytes_max.
   function automatic int unsigned len_width(input int unsigned bytes_max);
      return $clog2(bytes_max + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after `last`, wrapping cyclically.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   int unsigned cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      // i == NUM_REQ wraps back to `last` itself, so a lone requester can win again.
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(last) + i) % NUM_REQ;
         if (!gnt_any && req[IDX_W'(cand)]) begin
            gnt_any               = 1'b1;
            gnt[IDX_W'(cand)]     = 1'b1;
            gnt_idx               = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ sources; round-robin accept, then streams the
// latched payload LSB byte first through the Data_valid/Busy handshake.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned BYTES_MAX = 2,
   parameter int unsigned BUSY_TMO  = 16,
   localparam int unsigned LEN_W    = len_width(BYTES_MAX)
) (
   input  logic                           CLK,
   input  logic                           Reset,
   input  logic [NUM_REQ-1:0]             Req_valid,
   input  logic [NUM_REQ*BYTES_MAX*8-1:0] Req_data,
   input  logic [NUM_REQ*LEN_W-1:0]       Req_len,
   output logic [NUM_REQ-1:0]             Req_ready,
   input  logic                           Tx_busy,
   output logic [7:0]                     Tx_data,
   output logic                           Tx_data_valid,
   output logic [NUM_REQ-1:0]             Grant,
   output logic                           Sched_busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned PAY_W = BYTES_MAX * 8;
   localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);

   sched_state_e         state_q;
   logic [IDX_W-1:0]     rr_q;
   logic [PAY_W-1:0]     payload_q;
   logic [LEN_W-1:0]     len_q;
   logic [LEN_W-1:0]     idx_q;
   logic [TMO_W-1:0]     tmo_q;
   logic [7:0]           tx_data_q;
   logic                 tx_valid_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic                 busy_q;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;
   logic [PAY_W-1:0]     arb_payload;
   logic [LEN_W-1:0]     arb_len;
   logic [LEN_W-1:0]     arb_len_clamped;
   logic [7:0]           cur_byte;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req     (Req_valid),
      .last    (rr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   always_comb begin
      arb_payload = '0;
      arb_len     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            arb_payload = Req_data[i*PAY_W +: PAY_W];
            arb_len     = Req_len[i*LEN_W +: LEN_W];
         end
      end
      arb_len_clamped = (arb_len > LEN_W'(BYTES_MAX)) ? LEN_W'(BYTES_MAX) : arb_len;
   end

   always_comb begin
      cur_byte = '0;
      for (int unsigned b = 0; b < BYTES_MAX; b++) begin
         if (idx_q == LEN_W'(b)) begin
            cur_byte = payload_q[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= StIdle;
         rr_q       <= IDX_W'(NUM_REQ - 1);
         payload_q  <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         tmo_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         tx_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (|Req_valid) state_q <= StArb;
            end
            StArb: begin
               if (arb_any) begin
                  rr_q      <= arb_idx;
                  payload_q <= arb_payload;
                  len_q     <= arb_len_clamped;
                  idx_q     <= '0;
                  // A zero-length message is accepted and retired without touching the UART.
                  if (arb_len_clamped == '0) begin
                     state_q <= StIdle;
                  end else begin
                     grant_q <= arb_gnt;
                     busy_q  <= 1'b1;
                     state_q <= StIssue;
                  end
               end else begin
                  state_q <= StIdle;
               end
            end
            StIssue: begin
               if (!Tx_busy) begin
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= cur_byte;
                  tmo_q      <= '0;
                  state_q    <= StWaitHi;
               end
            end
            StWaitHi: begin
               if (Tx_busy) begin
                  state_q <= StWaitLo;
               end else if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
                  state_q <= StIssue;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            StWaitLo: begin
               if (!Tx_busy) begin
                  if (idx_q + LEN_W'(1) == len_q) begin
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     idx_q   <= idx_q + LEN_W'(1);
                     state_q <= StIssue;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign Req_ready     = (state_q == StArb) ? arb_gnt : '0;
   assign Tx_data       = tx_data_q;
   assign Tx_data_valid = tx_valid_q;
   assign Grant         = grant_q;
   assign Sched_busy    = busy_q;

endmodule
